uart_rx_fifo: RTL and testbench

Receive buffer sitting directly downstream of the UART receiver top. Captures each byte on the receiver's one-cycle done strobe, stores it in a first-word-fall-through FIFO, and presents it to the host/bus side with a read-pop handshake. Tracks fill level, almost-full, sticky overrun and a saturating framing-error count.

---
 rtl/uart_rx_fifo.sv | 106 ++++++++++
 tb/tb_uart_rx_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer behind the UART receiver.
// Each byte is captured on the receiver's one-cycle rx_done strobe. It is
// stored in a first-word-fall-through FIFO. The host side pops it with rd_en.
// The block also reports the fill level, almost-full, a sticky overrun flag
// and a saturating framing-error count.
//
// Optional feature: define UART_RX_FIFO_ERR_TAG_EN to store the framing-error
// flag with each byte. The flag then appears on rd_err. Without the macro,
// errored frames are dropped on the floor and rd_err is tied 0.
//
// Ports:
//   clk, arst_n        clock, asynchronous active-low reset
//   rx_data/rx_done/rx_err  byte, write strobe, framing error from receiver
//   rd_en              pop request (ignored while empty)
//   clr                synchronous flush of contents and status
//   rd_data/rd_err     head entry (FWFT), valid while rd_valid
//   level/full/afull   fill status
//   overrun            sticky: a byte was dropped because the FIFO was full
//   err_cnt            saturating count of errored frames
module uart_rx_fifo #(
   parameter  int DEPTH     = 16,
   parameter  int AFULL_LVL = 12,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          arst_n,
   input  logic [7:0]    rx_data,
   input  logic          rx_done,
   input  logic          rx_err,
   input  logic          rd_en,
   input  logic          clr,
   output logic [7:0]    rd_data,
   output logic          rd_err,
   output logic          rd_valid,
   output logic [AW:0]   level,
   output logic          full,
   output logic          afull,
   output logic          overrun,
   output logic [7:0]    err_cnt
);

`ifdef UART_RX_FIFO_ERR_TAG_EN
   localparam int EW = 9;
`else
   localparam int EW = 8;
`endif

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [EW-1:0] entry;
   logic          wr_req, wr_acc, rd_acc;

`ifdef UART_RX_FIFO_ERR_TAG_EN
   // Errored frames are kept and carry their tag.
   assign entry   = {rx_err, rx_data};
   assign wr_req  = rx_done;
   assign rd_err  = mem[rd_ptr][8];
`else
   // Errored frames never enter the FIFO, so they cannot cause an overrun.
   assign entry   = rx_data;
   assign wr_req  = rx_done & ~rx_err;
   assign rd_err  = 1'b0;
`endif

   assign rd_data  = mem[rd_ptr][7:0];
   assign rd_valid = (level != '0);
   assign full     = (level == (AW+1)'(DEPTH));
   assign afull    = (level >= (AW+1)'(AFULL_LVL));

   assign rd_acc = rd_en & rd_valid;
   // A write is accepted when the FIFO is full only if a pop frees a slot
   // on the same edge.
   assign wr_acc = wr_req & (~full | rd_acc);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         overrun <= 1'b0;
         err_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clr) begin
         // Flush wins over any concurrent write/read; memory is left as is.
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         overrun <= 1'b0;
         err_cnt <= '0;
      end else begin
         if (wr_acc) begin
            mem[wr_ptr] <= entry;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_acc, rd_acc})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (wr_req && !wr_acc) overrun <= 1'b1;
         if (rx_done && rx_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. It uses a queue-based reference model
// and checks the outputs on every falling edge. It also has directed literal
// expectations from the test plan and a randomized soak.
module tb_uart_rx_fifo;
   localparam int DEPTH = 16;
   localparam int AFULL = 12;
   localparam int AW    = $clog2(DEPTH);
`ifdef UART_RX_FIFO_ERR_TAG_EN
   localparam bit TAG = 1'b1;
`else
   localparam bit TAG = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          arst_n;
   logic [7:0]    rx_data;
   logic          rx_done, rx_err, rd_en, clr;
   logic [7:0]    rd_data;
   logic          rd_err, rd_valid, full, afull, overrun;
   logic [AW:0]   level;
   logic [7:0]    err_cnt;

   uart_rx_fifo #(.DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
      .clk(clk), .arst_n(arst_n), .rx_data(rx_data), .rx_done(rx_done),
      .rx_err(rx_err), .rd_en(rd_en), .clr(clr), .rd_data(rd_data),
      .rd_err(rd_err), .rd_valid(rd_valid), .level(level), .full(full),
      .afull(afull), .overrun(overrun), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: FIFO contents as a queue of {err, byte}.
   logic [8:0] q[$];
   bit         m_ovr;
   int         m_ecnt;
   bit         chk_en = 1'b0;
   int         checks = 0;
   int         failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ovr  = 1'b0;
      m_ecnt = 0;
   endtask

   task automatic model_step(input bit d, input logic [7:0] dat, input bit e,
                             input bit r, input bit c);
      bit wreq, racc, wacc;
      if (c) begin
         model_reset();
         return;
      end
      wreq = d && (TAG || !e);
      racc = r && (q.size() > 0);
      wacc = wreq && ((q.size() < DEPTH) || racc);
      if (d && e && m_ecnt < 255) m_ecnt++;
      if (racc) void'(q.pop_front());
      if (wreq && !wacc) m_ovr = 1'b1;
      if (wacc) q.push_back({(TAG ? e : 1'b0), dat});
   endtask

   // Apply one cycle of stimulus starting at a falling edge, then step the
   // model on the rising edge and return at the next falling edge.
   task automatic cyc(input bit d, input logic [7:0] dat, input bit e,
                      input bit r, input bit c);
      rx_done = d; rx_data = dat; rx_err = e; rd_en = r; clr = c;
      @(posedge clk);
      model_step(d, dat, e, r, c);
      @(negedge clk);
   endtask

   task automatic idle(); cyc(0, 8'h00, 0, 0, 0); endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en && arst_n) begin
         chk("rd_valid", int'(rd_valid), int'(q.size() > 0));
         chk("level",    int'(level),    q.size());
         chk("full",     int'(full),     int'(q.size() == DEPTH));
         chk("afull",    int'(afull),    int'(q.size() >= AFULL));
         chk("overrun",  int'(overrun),  int'(m_ovr));
         chk("err_cnt",  int'(err_cnt),  m_ecnt);
         if (q.size() > 0) begin
            chk("rd_data", int'(rd_data), int'(q[0][7:0]));
            chk("rd_err",  int'(rd_err),  int'(q[0][8]));
         end
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rd_data"},  int'(rd_data),  0);
      chk({tag, "_rd_err"},   int'(rd_err),   0);
      chk({tag, "_rd_valid"}, int'(rd_valid), 0);
      chk({tag, "_level"},    int'(level),    0);
      chk({tag, "_full"},     int'(full),     0);
      chk({tag, "_afull"},    int'(afull),    0);
      chk({tag, "_overrun"},  int'(overrun),  0);
      chk({tag, "_err_cnt"},  int'(err_cnt),  0);
   endtask

   initial begin
      arst_n = 1'b0; rx_done = 0; rx_data = 0; rx_err = 0; rd_en = 0; clr = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk_reset_outputs("rst");
      arst_n = 1'b1;
      chk_en = 1'b1;

      // Basic write/pop.
      cyc(1, 8'hA5, 0, 0, 0);
      cyc(1, 8'h3C, 0, 0, 0);
      chk("t1_level", int'(level), 2);
      chk("t1_head",  int'(rd_data), 'hA5);
      cyc(0, 8'h00, 0, 1, 0);
      chk("t1_pop1",  int'(rd_data), 'h3C);
      cyc(0, 8'h00, 0, 1, 0);
      chk("t1_empty", int'(rd_valid), 0);

      // Fill past full: 17 writes 0x00..0x10.
      for (int i = 0; i < 17; i++) begin
         cyc(1, 8'(i), 0, 0, 0);
         if (i == 10) chk("afull_at11", int'(afull), 0);
         if (i == 11) chk("afull_at12", int'(afull), 1);
      end
      chk("fill_full",    int'(full), 1);
      chk("fill_overrun", int'(overrun), 1);
      // Write and pop on a full FIFO: no drop, level stays 16.
      cyc(1, 8'hEE, 0, 1, 0);
      chk("fullrw_level", int'(level), 16);
      for (int i = 1; i < 16; i++) begin
         chk("drain_order", int'(rd_data), i);
         cyc(0, 8'h00, 0, 1, 0);
      end
      chk("drain_last", int'(rd_data), 'hEE);
      cyc(0, 8'h00, 0, 1, 0);
      cyc(0, 8'h00, 0, 0, 1);   // clear sticky overrun

      // Errored frame.
      cyc(1, 8'h55, 1, 0, 0);
      chk("err_cnt1", int'(err_cnt), 1);
      chk("err_level", int'(level), TAG ? 1 : 0);
      if (TAG) chk("err_tag", int'(rd_err), 1);
      cyc(0, 8'h00, 0, 0, 1);

      // Empty-FIFO read cases.
      cyc(0, 8'h00, 0, 1, 0);
      chk("empty_rd", int'(level), 0);
      cyc(1, 8'h77, 0, 1, 0);
      chk("empty_rw_level", int'(level), 1);
      chk("empty_rw_data",  int'(rd_data), 'h77);

      // Pointer wrap: 40 write/read cycles.
      for (int i = 0; i < 40; i++) cyc(1, 8'($urandom), 0, 1, 0);

      // Saturating error count.
      for (int i = 0; i < 300; i++) cyc(1, 8'($urandom), 1, 1, 0);
      chk("err_sat", int'(err_cnt), 255);

      // Clear with concurrent write: level 5, overrun set, err_cnt 3.
      cyc(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 17; i++) cyc(1, 8'(i), 0, 0, 0);
      while (q.size() > 5) cyc(0, 8'h00, 0, 1, 0);
      for (int i = 0; i < 3; i++) cyc(1, 8'h00, 1, 0, 0);
      chk("pre_clr_ecnt", int'(err_cnt), 3);
      chk("pre_clr_ovr",  int'(overrun), 1);
      cyc(1, 8'h99, 0, 0, 1);
      chk("clr_level", int'(level), 0);
      chk("clr_ovr",   int'(overrun), 0);
      chk("clr_ecnt",  int'(err_cnt), 0);

      // Randomized soak.
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 10,
             $urandom_range(0, 99) < ((i / 500) % 2 ? 70 : 35),
             $urandom_range(0, 999) < 5);
      end

      // Asynchronous reset in mid-stream.
      for (int i = 0; i < 6; i++) cyc(1, 8'(i + 1), i == 2, 0, 0);
      #2 arst_n = 1'b0;
      chk_en = 1'b0;
      #1 chk_reset_outputs("arst");
      model_reset();
      @(negedge clk);
      arst_n = 1'b1;
      chk_en = 1'b1;
      cyc(1, 8'h42, 0, 0, 0);
      chk("post_rst_data", int'(rd_data), 'h42);
      for (int i = 0; i < 200; i++)
         cyc($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 9) == 0,
             $urandom_range(0, 1), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
